ahb_bus_arbiter: RTL

Round-robin AHB bus arbiter that shares the multi-layer LCD interconnect between up to NUM_MASTERS bus masters (CPU, DMA, LCD frame fetch, test master). It samples HBUSREQ/HLOCK, issues a registered one-hot HGRANT, and drives HMASTER/HMASTLOCK. The address/control mux and the delayed write-data mux use these outputs in front of the slave-select decoder. A tenure counter bounds how long an unlocked master holds the bus.

---
 rtl/ahb_bus_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: registered one-hot HGRANT, tenure-bounded ownership,
// locked transfers, and HREADY-qualified HMASTER/HMASTLOCK address-phase tracking.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 16,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    typedef enum logic [1:0] {
        ST_DEFAULT,
        ST_ACTIVE,
        ST_LOCKED
    } state_t;

    localparam logic [MW-1:0]          DEF_IDX     = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT  = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [7:0]             TENURE_MAX  = 8'(MAX_TENURE);

    state_t                   state_reg, state_next;
    logic [MW-1:0]            g_reg, g_next;
    logic [MW-1:0]            rr_reg, rr_next;
    logic [7:0]               cnt_reg, cnt_next;
    logic [NUM_MASTERS-1:0]   grant_reg, grant_next;
    logic [MW-1:0]            hmaster_reg, hmaster_next;
    logic                     hmastlock_reg, hmastlock_next;

    logic                     expired;
    logic                     g_req;
    logic                     lock_hold;
    logic                     re_arb;
    logic                     found;
    logic [MW-1:0]            cand;
    logic [MW-1:0]            win;
    logic [NUM_MASTERS-1:0]   win_onehot;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
            assign win_onehot[gi] = (win == MW'(gi));
        end
    endgenerate

    // Rotating search from rr+1; an expired owner is only taken if nobody else asks.
    always_comb begin
        expired   = (cnt_reg == TENURE_MAX);
        g_req     = HBUSREQ[g_reg];
        lock_hold = (state_reg == ST_LOCKED) && HLOCK[g_reg];
        re_arb    = HREADY && !lock_hold &&
                    (!g_req || expired || (state_reg == ST_DEFAULT));
        found     = 1'b0;
        cand      = '0;
        win       = DEF_IDX;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = MW'((int'(rr_reg) + k) % NUM_MASTERS);
            if (!found && HBUSREQ[cand] && !((cand == g_reg) && expired)) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (!found && g_req) begin
            win = g_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        g_next         = g_reg;
        rr_next        = rr_reg;
        cnt_next       = cnt_reg;
        grant_next     = grant_reg;
        hmaster_next   = hmaster_reg;
        hmastlock_next = hmastlock_reg;
        if (HREADY) begin
            hmaster_next   = g_reg;
            hmastlock_next = HLOCK[g_reg];
            if (HTRANS[1] && grant_reg[g_reg] && !expired) begin
                cnt_next = cnt_reg + 8'd1;
            end
            if (re_arb) begin
                cnt_next = '0;
                if (win != g_reg) begin
                    g_next     = win;
                    rr_next    = win;
                    grant_next = win_onehot;
                end
                if (!(|HBUSREQ)) begin
                    state_next = ST_DEFAULT;
                end else if (HLOCK[win]) begin
                    state_next = ST_LOCKED;
                end else begin
                    state_next = ST_ACTIVE;
                end
            end else begin
                state_next = HLOCK[g_reg] ? ST_LOCKED : ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= ST_DEFAULT;
            g_reg         <= DEF_IDX;
            rr_reg        <= DEF_IDX;
            cnt_reg       <= '0;
            grant_reg     <= DEF_ONEHOT;
            hmaster_reg   <= DEF_IDX;
            hmastlock_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            g_reg         <= g_next;
            rr_reg        <= rr_next;
            cnt_reg       <= cnt_next;
            grant_reg     <= grant_next;
            hmaster_reg   <= hmaster_next;
            hmastlock_reg <= hmastlock_next;
        end
    end

    assign HGRANT    = grant_reg;
    assign HMASTER   = hmaster_reg;
    assign HMASTLOCK = hmastlock_reg;

endmodule
